// File: rtl/alu_exec_unit_if.sv
// Valid/ready request and result bundle between the execute stage and alu_exec_unit.
// The slave modport is the ALU side; the master modport is the pipeline side.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       aluop;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       ctrl_code;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, aluop, func3, func7, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, ctrl_code, zero, illegal
    );

    modport slave (
        input  in_valid, aluop, func3, func7, op_a, op_b, out_ready,
        output in_ready, out_valid, result, ctrl_code, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes aluop/func3/func7, runs single-cycle ops, iterative shifts and,
// when ALU_MUL_EN is defined, a shift-add multiplier; valid/ready handshake on both sides.
module alu_exec_unit #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1,
    parameter int SHAMT_W    = $clog2(WIDTH)
) (
    input logic            clk,
    input logic            rst,
    alu_exec_unit_if.slave bus
);

    localparam logic [3:0] CTRL_AND = 4'b0001;
    localparam logic [3:0] CTRL_OR  = 4'b0010;
    localparam logic [3:0] CTRL_XOR = 4'b0011;
    localparam logic [3:0] CTRL_ADD = 4'b0100;
    localparam logic [3:0] CTRL_SUB = 4'b0101;
    localparam logic [3:0] CTRL_SRL = 4'b0110;
    localparam logic [3:0] CTRL_SLL = 4'b0111;
    localparam logic [3:0] CTRL_SLT = 4'b1000;
    localparam logic [3:0] CTRL_ILL = 4'b1111;
`ifdef ALU_MUL_EN
    localparam logic [3:0]         CTRL_MUL = 4'b1001;
    localparam logic [SHAMT_W-1:0] MUL_LAST = SHAMT_W'(WIDTH - 1);
`endif
    localparam logic [SHAMT_W:0] STEP_L = (SHAMT_W + 1)'(SHIFT_STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_MUL   = 2'b10,
        ST_HOLD  = 2'b11
    } state_t;

    function automatic logic [3:0] decode_ctrl(input logic [1:0] aluop,
                                               input logic [2:0] func3,
                                               input logic [6:0] func7);
        logic [3:0] c;
        case (aluop)
            2'b00: c = CTRL_ADD;
            2'b01: c = CTRL_SUB;
            2'b10: begin
                case (func3)
                    3'b000: begin
                        if (func7 == 7'b0000000) c = CTRL_ADD;
                        else if (func7 == 7'b0100000) c = CTRL_SUB;
`ifdef ALU_MUL_EN
                        else if (func7 == 7'b0000001) c = CTRL_MUL;
`endif
                        else c = CTRL_ILL;
                    end
                    3'b001:  c = CTRL_XOR;
                    3'b010:  c = CTRL_OR;
                    3'b011:  c = CTRL_AND;
                    3'b100:  c = CTRL_SRL;
                    3'b101:  c = CTRL_SLL;
                    3'b110:  c = CTRL_SLT;
                    default: c = CTRL_ILL;
                endcase
            end
            default: c = CTRL_ILL;
        endcase
        return c;
    endfunction

    // Shift codes only reach this path with a zero shift amount, so they pass op_a through.
    function automatic logic [WIDTH-1:0] exec_single(input logic [3:0]       ctrl,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (ctrl)
            CTRL_ADD: r = a + b;
            CTRL_SUB: r = a - b;
            CTRL_XOR: r = a ^ b;
            CTRL_OR:  r = a | b;
            CTRL_AND: r = a & b;
            CTRL_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            CTRL_SRL: r = a;
            CTRL_SLL: r = a;
            default:  r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic [3:0]         ctrl_code_r;
    logic               zero_r;
    logic               illegal_r;
    logic               arith_r;
    logic               left_r;
    logic [WIDTH-1:0]   work_r;
    logic [SHAMT_W-1:0] count_r;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   acc_nx_s;
`endif

    logic               accept_s;
    logic [3:0]         dec_ctrl_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic               is_shift_s;
    logic [WIDTH-1:0]   single_res_s;
    logic [SHAMT_W:0]   rem_ext_s;
    logic [SHAMT_W:0]   step_amt_s;
    logic               shift_last_s;
    logic               mul_last_s;
    logic [WIDTH-1:0]   shift_nx_s;

    assign accept_s     = bus.in_valid && (state_r == ST_IDLE);
    assign dec_ctrl_s   = decode_ctrl(bus.aluop, bus.func3, bus.func7);
    assign shamt_s      = bus.op_b[SHAMT_W-1:0];
    assign is_shift_s   = (dec_ctrl_s == CTRL_SRL) || (dec_ctrl_s == CTRL_SLL);
    assign single_res_s = exec_single(dec_ctrl_s, bus.op_a, bus.op_b);
    assign rem_ext_s    = {1'b0, count_r};
    assign step_amt_s   = (rem_ext_s < STEP_L) ? rem_ext_s : STEP_L;
    assign shift_last_s = (rem_ext_s == step_amt_s);
    assign mul_last_s   = (count_r == {SHAMT_W{1'b0}});

    // One shift step of the working operand; arithmetic right shifts replicate the sign bit.
    always_comb begin
        if (left_r) begin
            shift_nx_s = work_r << step_amt_s;
        end else if (arith_r) begin
            shift_nx_s = $signed(work_r) >>> step_amt_s;
        end else begin
            shift_nx_s = work_r >> step_amt_s;
        end
    end

`ifdef ALU_MUL_EN
    // Shift-add partial product: work_r carries the multiplicand aligned to the current bit.
    always_comb begin
        if (mplier_r[0]) begin
            acc_nx_s = acc_r + work_r;
        end else begin
            acc_nx_s = acc_r;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; no accept while HOLD drains, so throughput is one op per two cycles.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_shift_s && (shamt_s != {SHAMT_W{1'b0}})) state_nx_s = ST_SHIFT;
`ifdef ALU_MUL_EN
                    else if (dec_ctrl_s == CTRL_MUL) state_nx_s = ST_MUL;
`endif
                    else state_nx_s = ST_HOLD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (shift_last_s) state_nx_s = ST_HOLD;
                else state_nx_s = ST_SHIFT;
            end
            ST_MUL: begin
                if (mul_last_s) state_nx_s = ST_HOLD;
                else state_nx_s = ST_MUL;
            end
            ST_HOLD: begin
                if (bus.out_ready) state_nx_s = ST_IDLE;
                else state_nx_s = ST_HOLD;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; result and zero load together when entering HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            ctrl_code_r <= 4'b0000;
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
            arith_r     <= 1'b0;
            left_r      <= 1'b0;
            work_r      <= {WIDTH{1'b0}};
            count_r     <= {SHAMT_W{1'b0}};
`ifdef ALU_MUL_EN
            acc_r       <= {WIDTH{1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
`endif
        end else begin
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_HOLD);
            if (accept_s) begin
                ctrl_code_r <= dec_ctrl_s;
                illegal_r   <= (dec_ctrl_s == CTRL_ILL);
                arith_r     <= bus.func7[5];
                left_r      <= (dec_ctrl_s == CTRL_SLL);
                work_r      <= bus.op_a;
                count_r     <= shamt_s;
`ifdef ALU_MUL_EN
                acc_r       <= {WIDTH{1'b0}};
                mplier_r    <= bus.op_b;
                if (dec_ctrl_s == CTRL_MUL) count_r <= MUL_LAST;
`endif
                if (state_nx_s == ST_HOLD) begin
                    result_r <= single_res_s;
                    zero_r   <= (single_res_s == {WIDTH{1'b0}});
                end
            end else if (state_r == ST_SHIFT) begin
                work_r  <= shift_nx_s;
                count_r <= count_r - step_amt_s[SHAMT_W-1:0];
                if (shift_last_s) begin
                    result_r <= shift_nx_s;
                    zero_r   <= (shift_nx_s == {WIDTH{1'b0}});
                end
            end
`ifdef ALU_MUL_EN
            else if (state_r == ST_MUL) begin
                acc_r    <= acc_nx_s;
                work_r   <= work_r << 1;
                mplier_r <= mplier_r >> 1;
                count_r  <= count_r - {{(SHAMT_W-1){1'b0}}, 1'b1};
                if (mul_last_s) begin
                    result_r <= acc_nx_s;
                    zero_r   <= (acc_nx_s == {WIDTH{1'b0}});
                end
            end
`endif
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.ctrl_code = ctrl_code_r;
    assign bus.zero      = zero_r;
    assign bus.illegal   = illegal_r;

endmodule
